// File: rtl/rom_word_fetcher_pkg.sv
// Shared CPU-side constants and state encoding for the byte-wide program ROM reader.
package rom_word_fetcher_pkg;

    localparam int ROM_ADDR_W = 32;
    localparam int ROM_DATA_W = 8;
    localparam int WORD_W     = 32;
    localparam int MAX_BYTES  = WORD_W / ROM_DATA_W;

    localparam logic [ROM_ADDR_W-1:0] RESET_ADDR_DEFAULT = 32'h0000_0000;

    typedef enum logic {
        FETCH_S = 1'b0,
        HOLD_S  = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/rom_word_fetcher.sv
// Fetches consecutive ROM bytes, packs them little-endian into a word and offers the word
// to the decode stage over valid/ready; a redirect restarts fetching at any byte address.
module rom_word_fetcher
    import rom_word_fetcher_pkg::*;
#(
    parameter int                     BYTES_PER_WORD = 4,
    parameter logic [ROM_ADDR_W-1:0]  RESET_ADDR     = RESET_ADDR_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fetch_en,
    input  logic                  redirect,
    input  logic [ROM_ADDR_W-1:0] redirect_addr,
    output logic [ROM_ADDR_W-1:0] rom_addr,
    input  logic [ROM_DATA_W-1:0] rom_byte,
    output logic                  word_valid,
    input  logic                  word_ready,
    output logic [WORD_W-1:0]     word,
    output logic [ROM_ADDR_W-1:0] word_addr
);

    localparam logic [1:0]            LAST_CNT  = 2'(BYTES_PER_WORD - 1);
    localparam logic [ROM_ADDR_W-1:0] ADDR_BACK = ROM_ADDR_W'(BYTES_PER_WORD - 1);

    fetch_state_e                          state_q, state_d;
    logic [ROM_ADDR_W-1:0]                 rom_addr_q, rom_addr_d;
    logic [1:0]                            cnt_q, cnt_d;
    logic [MAX_BYTES-1:0][ROM_DATA_W-1:0]  lanes_q, lanes_d;
    logic [WORD_W-1:0]                     word_q, word_d;
    logic [ROM_ADDR_W-1:0]                 word_addr_q, word_addr_d;
    logic                                  word_valid_q, word_valid_d;
    logic [WORD_W-1:0]                     assembled;

    always_comb begin
        state_d      = state_q;
        rom_addr_d   = rom_addr_q;
        cnt_d        = cnt_q;
        lanes_d      = lanes_q;
        word_d       = word_q;
        word_addr_d  = word_addr_q;
        word_valid_d = word_valid_q;
        assembled    = '0;

        // The byte arriving this cycle is merged in directly so the word completes on its last fetch.
        for (int i = 0; i < MAX_BYTES; i++) begin
            if (i < BYTES_PER_WORD) begin
                assembled[i*ROM_DATA_W +: ROM_DATA_W] = (2'(i) == cnt_q) ? rom_byte : lanes_q[i];
            end
        end

        case (state_q)
            FETCH_S: begin
                if (fetch_en) begin
                    lanes_d[cnt_q] = rom_byte;
                    rom_addr_d     = rom_addr_q + ROM_ADDR_W'(1);
                    if (cnt_q == LAST_CNT) begin
                        word_d       = assembled;
                        word_addr_d  = rom_addr_q - ADDR_BACK;
                        word_valid_d = 1'b1;
                        state_d      = HOLD_S;
                    end else begin
                        cnt_d = cnt_q + 2'd1;
                    end
                end
            end
            HOLD_S: begin
                if (word_valid_q && word_ready) begin
                    word_valid_d = 1'b0;
                    cnt_d        = '0;
                    state_d      = FETCH_S;
                end
            end
            default: state_d = FETCH_S;
        endcase

        if (redirect) begin
            rom_addr_d   = redirect_addr;
            cnt_d        = '0;
            lanes_d      = '0;
            word_valid_d = 1'b0;
            state_d      = FETCH_S;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= FETCH_S;
            rom_addr_q   <= RESET_ADDR;
            cnt_q        <= '0;
            lanes_q      <= '0;
            word_q       <= '0;
            word_addr_q  <= '0;
            word_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            rom_addr_q   <= rom_addr_d;
            cnt_q        <= cnt_d;
            lanes_q      <= lanes_d;
            word_q       <= word_d;
            word_addr_q  <= word_addr_d;
            word_valid_q <= word_valid_d;
        end
    end

    assign rom_addr   = rom_addr_q;
    assign word_valid = word_valid_q;
    assign word       = word_q;
    assign word_addr  = word_addr_q;

endmodule
